pdp1_cpu_alu_div_seq: RTL

- Parametrised, multi-cycle restoring radix-2 divider for the PDP-1 CPU ALU.
- Replaces the single-cycle combinational divide path.
- Adds a start/busy/done handshake, a ones'-complement signed mode for PDP-1 DIV semantics, and divide-by-zero and quotient-overflow flags.
- Sits beside the ALU; the CPU sequencer holds the DIV instruction until done.

---
 rtl/pdp1_cpu_alu_div_seq_if.sv | 28 ++
 rtl/pdp1_cpu_alu_div_seq.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pdp1_cpu_alu_div_seq_if.sv
// Start/busy/done handshake and operand/result bus between the CPU sequencer
// and the multi-cycle DIV unit.
interface pdp1_cpu_alu_div_seq_if #(
  parameter int NUM_W = 34,
  parameter int DEN_W = 17,
  parameter int QUO_W = 34
);
  logic             start;
  logic             signed_mode;
  logic [NUM_W-1:0] numer;
  logic [DEN_W-1:0] denom;
  logic             busy;
  logic             done;
  logic [QUO_W-1:0] quotient;
  logic [DEN_W-1:0] remain;
  logic             div_zero;
  logic             overflow;

  modport master (
    output start, signed_mode, numer, denom,
    input  busy, done, quotient, remain, div_zero, overflow
  );

  modport slave (
    input  start, signed_mode, numer, denom,
    output busy, done, quotient, remain, div_zero, overflow
  );
endinterface

// File: rtl/pdp1_cpu_alu_div_seq.sv
// Multi-cycle restoring radix-2 divider for the PDP-1 DIV instruction, with
// ones'-complement signed mode and divide-by-zero / quotient-overflow flags.
//
// state | meaning
// IDLE  | waiting for start; operands captured on acceptance
// PREP  | take magnitudes and signs, catch divide-by-zero
// ITER  | one quotient bit per cycle, MSB first, NUM_W cycles
// FIX   | overflow check and sign restoration
// DONE  | done pulse, results valid
module pdp1_cpu_alu_div_seq #(
  parameter int NUM_W = 34,
  parameter int DEN_W = 17,
  parameter int QUO_W = 34
) (
  input logic                    in_clock,
  input logic                    in_reset_n,
  pdp1_cpu_alu_div_seq_if.slave  bus
);

  localparam int CW = (NUM_W > 1) ? $clog2(NUM_W) : 1;

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NUM_W-1:0] sr_q, sr_d;
  logic [DEN_W-1:0] prem_q, prem_d;
  logic [DEN_W-1:0] dmag_q, dmag_d;
  logic             smode_q, smode_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [QUO_W-1:0] quo_q, quo_d;
  logic [DEN_W-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;

  logic [DEN_W:0]   prem_sh;
  logic [DEN_W-1:0] prem_sub;
  logic             ge;
  logic             nneg, dneg;
  logic [NUM_W-1:0] nmag;
  logic [DEN_W-1:0] dmag_v;
  logic             ovf_v;
  int               ovf_lim;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    prem_d   = prem_q;
    dmag_d   = dmag_q;
    smode_d  = smode_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;

    // Partial remainder widened by one bit so the compare sees the shifted-in MSB.
    prem_sh  = {prem_q, sr_q[NUM_W-1]};
    ge       = (prem_sh >= {1'b0, dmag_q});
    prem_sub = prem_sh[DEN_W-1:0] - dmag_q;

    nneg     = smode_q & sr_q[NUM_W-1];
    dneg     = smode_q & dmag_q[DEN_W-1];
    nmag     = nneg ? ~sr_q : sr_q;
    dmag_v   = dneg ? ~dmag_q : dmag_q;

    ovf_lim  = smode_q ? (QUO_W - 1) : QUO_W;
    ovf_v    = 1'b0;
    for (int i = 0; i < NUM_W; i++) begin
      if (i >= ovf_lim && sr_q[i]) ovf_v = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          sr_d    = bus.numer;
          dmag_d  = bus.denom;
          smode_d = bus.signed_mode;
          busy_d  = 1'b1;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        qneg_d = nneg ^ dneg;
        rneg_d = nneg;
        if (dmag_v == '0) begin
          quo_d   = '1;
          rem_d   = '1;
          dz_d    = 1'b1;
          ovf_d   = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          prem_d  = '0;
          sr_d    = nmag;
          dmag_d  = dmag_v;
          cnt_d   = CW'(NUM_W - 1);
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        prem_d = ge ? prem_sub : prem_sh[DEN_W-1:0];
        sr_d   = (sr_q << 1) | NUM_W'(ge);
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_FIX: begin
        dz_d   = 1'b0;
        ovf_d  = ovf_v;
        if (ovf_v) begin
          quo_d = sr_q[QUO_W-1:0];
          rem_d = prem_q;
        end else begin
          quo_d = qneg_q ? ~sr_q[QUO_W-1:0] : sr_q[QUO_W-1:0];
          rem_d = rneg_q ? ~prem_q : prem_q;
        end
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge in_clock) begin
    if (!in_reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      prem_q  <= '0;
      dmag_q  <= '0;
      smode_q <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      prem_q  <= prem_d;
      dmag_q  <= dmag_d;
      smode_q <= smode_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.quotient = quo_q;
  assign bus.remain   = rem_q;
  assign bus.div_zero = dz_q;
  assign bus.overflow = ovf_q;

endmodule
